// File: rtl/rst_seq_sword.sv
// Reset sequencer for one generated clock domain: waits for a stable MMCM lock,
// releases peripherals, then the core; handles lock loss and software core resets.
module rst_seq_sword #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 256,
    parameter int PERIPH_GAP    = 16,
    parameter int SW_HOLD       = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       sw_rst_req,
    output logic       rst_periph,
    output logic       rst_core,
    output logic       ready,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_dbg
);

    localparam int MAX_AB  = (STABLE_CYCLES > PERIPH_GAP) ? STABLE_CYCLES : PERIPH_GAP;
    localparam int MAX_CYC = (MAX_AB > SW_HOLD) ? MAX_AB : SW_HOLD;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(PERIPH_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(SW_HOLD - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABILIZE = 3'd1,
        ST_PERIPH_ON = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_HOLD   = 3'd4
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_WAIT_LOCK;
            cnt           <= '0;
            rst_periph    <= 1'b1;
            rst_core      <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    rst_periph <= 1'b1;
                    rst_core   <= 1'b1;
                    ready      <= 1'b0;
                    cnt        <= '0;
                    if (lock_s) begin
                        state <= ST_STABILIZE;
                    end
                end
                // A lock drop before peripherals are released is not a counted loss.
                ST_STABILIZE: begin
                    if (!lock_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state      <= ST_PERIPH_ON;
                        rst_periph <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PERIPH_ON, ST_RUN, ST_SW_HOLD: begin
                    if (!lock_s) begin
                        state      <= ST_WAIT_LOCK;
                        rst_periph <= 1'b1;
                        rst_core   <= 1'b1;
                        ready      <= 1'b0;
                        cnt        <= '0;
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                    end else if (state == ST_RUN) begin
                        if (sw_rst_req) begin
                            state    <= ST_SW_HOLD;
                            rst_core <= 1'b1;
                            ready    <= 1'b0;
                            cnt      <= '0;
                        end
                    end else if (cnt == ((state == ST_PERIPH_ON) ? GAP_LAST : HOLD_LAST)) begin
                        state    <= ST_RUN;
                        rst_core <= 1'b0;
                        ready    <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= ST_WAIT_LOCK;
                    rst_periph <= 1'b1;
                    rst_core   <= 1'b1;
                    ready      <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_sword.sv
// Directed bench for rst_seq_sword: default-parameter instance for sequencing,
// plus a fast-parameter instance for lock-loss counter saturation.
module tb_rst_seq_sword;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, locked, sw_rst_req;
    logic       rst_periph, rst_core, ready;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_dbg;

    logic       locked2, sw_rst_req2;
    logic       rst_periph2, rst_core2, ready2;
    logic [7:0] lock_loss_cnt2;
    logic [2:0] state_dbg2;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    rst_seq_sword dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .locked        (locked),
        .sw_rst_req    (sw_rst_req),
        .rst_periph    (rst_periph),
        .rst_core      (rst_core),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .state_dbg     (state_dbg)
    );

    rst_seq_sword #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (2),
        .PERIPH_GAP    (1),
        .SW_HOLD       (1)
    ) dut_fast (
        .clk           (clk),
        .rst_n         (rst_n),
        .locked        (locked2),
        .sw_rst_req    (sw_rst_req2),
        .rst_periph    (rst_periph2),
        .rst_core      (rst_core2),
        .ready         (ready2),
        .lock_loss_cnt (lock_loss_cnt2),
        .state_dbg     (state_dbg2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        locked      = 1'b1;
        sw_rst_req  = 1'b0;
        locked2     = 1'b0;
        sw_rst_req2 = 1'b0;

        // Power-up
        step(5);
        check("rst_periph_in_reset", rst_periph, 1);
        check("rst_core_in_reset", rst_core, 1);
        check("ready_in_reset", ready, 0);
        check("loss_in_reset", lock_loss_cnt, 0);
        check("state_in_reset", state_dbg, 0);
        rst_n = 1'b1;
        step(258);
        check("pu_periph_E257", rst_periph, 1);
        check("pu_state_E257", state_dbg, 1);
        step(1);
        check("pu_periph_E258", rst_periph, 0);
        check("pu_core_E258", rst_core, 1);
        check("pu_state_E258", state_dbg, 2);
        step(15);
        check("pu_core_E273", rst_core, 1);
        check("pu_ready_E273", ready, 0);
        step(1);
        check("pu_core_E274", rst_core, 0);
        check("pu_ready_E274", ready, 1);
        check("pu_state_E274", state_dbg, 3);
        check("pu_loss_E274", lock_loss_cnt, 0);

        // Lock loss in RUN
        locked = 1'b0;
        step(2);
        check("loss_ready_E1", ready, 1);
        step(1);
        check("loss_periph_E2", rst_periph, 1);
        check("loss_core_E2", rst_core, 1);
        check("loss_ready_E2", ready, 0);
        check("loss_state_E2", state_dbg, 0);
        check("loss_cnt_E2", lock_loss_cnt, 1);

        // Glitchy relock: 100 high, 3 low, then high (G0 = final rise)
        locked = 1'b1;
        step(100);
        locked = 1'b0;
        step(3);
        locked = 1'b1;
        step(258);
        check("glitch_periph_G257", rst_periph, 1);
        check("glitch_state_G257", state_dbg, 1);
        step(1);
        check("glitch_periph_G258", rst_periph, 0);
        check("glitch_state_G258", state_dbg, 2);
        check("glitch_loss", lock_loss_cnt, 1);

        // sw_rst_req during PERIPH_ON is ignored
        step(1);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check("po_sw_state", state_dbg, 2);
        check("po_sw_core", rst_core, 1);
        step(14);
        check("po_sw_run_state", state_dbg, 3);
        check("po_sw_run_ready", ready, 1);
        step(1);
        check("po_sw_stays_run", state_dbg, 3);
        check("po_sw_core_low", rst_core, 0);

        // Software reset: pulse at S, second pulse at S+10
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check("sw_core_S", rst_core, 1);
        check("sw_ready_S", ready, 0);
        check("sw_periph_S", rst_periph, 0);
        check("sw_state_S", state_dbg, 4);
        step(9);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(53);
        check("sw_core_S63", rst_core, 1);
        check("sw_state_S63", state_dbg, 4);
        check("sw_periph_S63", rst_periph, 0);
        step(1);
        check("sw_core_S64", rst_core, 0);
        check("sw_ready_S64", ready, 1);
        check("sw_state_S64", state_dbg, 3);

        // lock_s falls on the same edge sw_rst_req is high
        locked = 1'b0;
        step(2);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check("simul_state", state_dbg, 0);
        check("simul_loss", lock_loss_cnt, 2);
        check("simul_core", rst_core, 1);
        check("simul_periph", rst_periph, 1);
        check("simul_ready", ready, 0);

        // Relock, then lock drop during SW_HOLD
        locked = 1'b1;
        step(275);
        check("relock_state", state_dbg, 3);
        check("relock_ready", ready, 1);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        locked = 1'b0;
        step(2);
        check("swdrop_state_S2", state_dbg, 4);
        check("swdrop_periph_S2", rst_periph, 0);
        step(1);
        check("swdrop_state_S3", state_dbg, 0);
        check("swdrop_periph_S3", rst_periph, 1);
        check("swdrop_core_S3", rst_core, 1);
        check("swdrop_loss_S3", lock_loss_cnt, 3);

        // Saturation on the fast instance: one counted loss per 12-cycle loop
        for (int i = 0; i < 260; i++) begin
            locked2 = 1'b1;
            step(8);
            if (i == 0) begin
                check("fast_run_ready", ready2, 1);
            end
            locked2 = 1'b0;
            step(4);
            if (i == 0) begin
                check("fast_loss_1", lock_loss_cnt2, 1);
            end
            if (i == 254) begin
                check("fast_loss_255", lock_loss_cnt2, 255);
            end
        end
        check("fast_loss_sat", lock_loss_cnt2, 255);
        check("fast_state_wait", state_dbg2, 0);

        // Async reset mid-PERIPH_ON, asserted between clock edges
        locked = 1'b1;
        step(261);
        check("pre_arst_state", state_dbg, 2);
        check("pre_arst_periph", rst_periph, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_periph", rst_periph, 1);
        check("arst_core", rst_core, 1);
        check("arst_ready", ready, 0);
        check("arst_loss", lock_loss_cnt, 0);
        check("arst_state", state_dbg, 0);
        check("arst_fast_loss", lock_loss_cnt2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
